pll_reset_seq: RTL and testbench

//  Supervises the board PLL (SB_PLL40_CORE) from the 12 MHz reference clock.
//  - Drives the PLL RESETB input.
//  - Waits for LOCK, qualifies it as stable, then releases the core reset.
//  - Retries the PLL on lock timeout; reasserts core reset on lock loss.
//  - Latches a permanent FAIL after repeated timeouts.

---
 rtl/pll_reset_seq.sv | 157 +++++++++++++++
 tb/tb_pll_reset_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// PLL supervisor: sequences RESETB, qualifies lock and gates the core reset.
// Retries on lock timeout, resequences on lock loss, latches FAIL after too many timeouts.
module pll_reset_seq #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 4096,
   parameter int STABLE_CYCLES = 256,
   parameter int MAX_RETRIES   = 3,
   localparam int RW   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1,
   localparam int CM1  = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES,
   localparam int CMAX = (CM1 > RST_CYCLES) ? CM1 : RST_CYCLES,
   localparam int CW   = $clog2(CMAX + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pll_lock,
   output logic          pll_resetb,
   output logic          sys_rst,
   output logic          ready,
   output logic          fail,
   output logic [RW-1:0] retries,
   output logic [7:0]    loss_cnt
);

   typedef enum logic [2:0] {
      PLL_RST,
      WAIT_LOCK,
      STABLE,
      RUN,
      FAIL
   } state_t;

   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [RW-1:0] retries_d;
   logic [7:0]    loss_d;
   logic          lock_m, lock_s;
   logic          resetb_d, sys_rst_d, ready_d, fail_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= pll_lock;
         lock_s <= lock_m;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= PLL_RST;
         cnt        <= '0;
         retries    <= '0;
         loss_cnt   <= '0;
         pll_resetb <= 1'b0;
         sys_rst    <= 1'b1;
         ready      <= 1'b0;
         fail       <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         retries    <= retries_d;
         loss_cnt   <= loss_d;
         pll_resetb <= resetb_d;
         sys_rst    <= sys_rst_d;
         ready      <= ready_d;
         fail       <= fail_d;
      end
   end

   // cnt only advances in timed states, so it never wraps
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      retries_d = retries;
      loss_d    = loss_cnt;
      unique case (state)
         PLL_RST: begin
            if (cnt == CW'(RST_CYCLES - 1)) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_d = STABLE;
               cnt_d   = '0;
            end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
               cnt_d = '0;
               if (retries == RW'(MAX_RETRIES)) begin
                  state_d = FAIL;
               end else begin
                  state_d   = PLL_RST;
                  retries_d = retries + RW'(1);
               end
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end
         STABLE: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
               state_d   = RUN;
               cnt_d     = '0;
               retries_d = '0;
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_d = PLL_RST;
               cnt_d   = '0;
               if (loss_cnt != 8'hff) begin
                  loss_d = loss_cnt + 8'd1;
               end
            end
         end
         FAIL: begin
            state_d = FAIL;
         end
         default: begin
            state_d = PLL_RST;
            cnt_d   = '0;
         end
      endcase
   end

   // outputs decode the next state so they move on the same edge as state
   always_comb begin
      resetb_d  = 1'b0;
      sys_rst_d = 1'b1;
      ready_d   = 1'b0;
      fail_d    = 1'b0;
      unique case (state_d)
         WAIT_LOCK, STABLE: begin
            resetb_d = 1'b1;
         end
         RUN: begin
            resetb_d  = 1'b1;
            sys_rst_d = 1'b0;
            ready_d   = 1'b1;
         end
         FAIL: begin
            fail_d = 1'b1;
         end
         default: begin
            resetb_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: directed vector table on the default build,
// randomized lock traffic against a phase/time model on a short-timing build.
module tb_pll_reset_seq;

   localparam int SR = 3;
   localparam int ST = 20;
   localparam int SS = 6;

   localparam int PH_RST  = 0;
   localparam int PH_WAIT = 1;
   localparam int PH_QUAL = 2;
   localparam int PH_RUN  = 3;
   localparam int PH_DEAD = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_rst, a_lock, a_resetb, a_sysrst, a_ready, a_fail;
   logic [1:0] a_retries;
   logic [7:0] a_loss;
   logic       b_rst, b_lock, b_resetb, b_sysrst, b_ready, b_fail;
   logic [1:0] b_retries;
   logic [7:0] b_loss;

   pll_reset_seq dut_a (
      .clk(clk), .rst(a_rst), .pll_lock(a_lock),
      .pll_resetb(a_resetb), .sys_rst(a_sysrst), .ready(a_ready),
      .fail(a_fail), .retries(a_retries), .loss_cnt(a_loss)
   );

   pll_reset_seq #(
      .RST_CYCLES(SR), .LOCK_TIMEOUT(ST),
      .STABLE_CYCLES(SS), .MAX_RETRIES(3)
   ) dut_b (
      .clk(clk), .rst(b_rst), .pll_lock(b_lock),
      .pll_resetb(b_resetb), .sys_rst(b_sysrst), .ready(b_ready),
      .fail(b_fail), .retries(b_retries), .loss_cnt(b_loss)
   );

   int checks = 0;
   int failures = 0;

   typedef struct {
      bit          rst;
      bit          lock;
      int          n;
      logic [13:0] exp;
   } vec_t;

   vec_t tv[$];

   function automatic logic [13:0] pack(bit pb, bit sr, bit rd, bit fl,
                                        int rt, int ls);
      return {pb, sr, rd, fl, 2'(rt), 8'(ls)};
   endfunction

   task automatic add(bit r, bit l, int n, bit pb, bit sr, bit rd,
                      bit fl, int rt, int ls);
      vec_t v;
      v.rst  = r;
      v.lock = l;
      v.n    = n;
      v.exp  = pack(pb, sr, rd, fl, rt, ls);
      tv.push_back(v);
   endtask

   int m_ph, m_t0, m_try, m_loss, cyc;
   bit m_s0, m_s1;

   task automatic go(int ph);
      m_ph = ph;
      m_t0 = cyc;
   endtask

   task automatic model_step(bit r, bit lk);
      bit ls;
      cyc++;
      ls   = m_s1;
      m_s1 = m_s0;
      m_s0 = lk;
      if (r) begin
         m_s0   = 0;
         m_s1   = 0;
         m_try  = 0;
         m_loss = 0;
         go(PH_RST);
      end else begin
         case (m_ph)
            PH_RST:  if (cyc - m_t0 == SR) go(PH_WAIT);
            PH_WAIT: begin
               if (ls) go(PH_QUAL);
               else if (cyc - m_t0 == ST) begin
                  if (m_try == 3) go(PH_DEAD);
                  else begin
                     m_try++;
                     go(PH_RST);
                  end
               end
            end
            PH_QUAL: begin
               if (!ls) go(PH_WAIT);
               else if (cyc - m_t0 == SS) begin
                  m_try = 0;
                  go(PH_RUN);
               end
            end
            PH_RUN: begin
               if (!ls) begin
                  if (m_loss < 255) m_loss++;
                  go(PH_RST);
               end
            end
            default: ;
         endcase
      end
   endtask

   function automatic logic [13:0] model_out();
      bit pb;
      pb = (m_ph == PH_WAIT) || (m_ph == PH_QUAL) || (m_ph == PH_RUN);
      return pack(pb, m_ph != PH_RUN, m_ph == PH_RUN,
                  m_ph == PH_DEAD, m_try, m_loss);
   endfunction

   task automatic b_edge();
      logic [13:0] got, exp;
      @(posedge clk);
      model_step(b_rst, b_lock);
      #1;
      got = {b_resetb, b_sysrst, b_ready, b_fail, b_retries, b_loss};
      exp = model_out();
      checks++;
      if (got !== exp) begin
         failures++;
         if (failures < 20)
            $display("FAIL rand cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
   endtask

   initial begin
      logic [13:0] got;
      bit lk;
      int len;
      a_rst  = 1'b1;
      a_lock = 1'b1;
      b_rst  = 1'b1;
      b_lock = 1'b0;

      // power-up latency with lock held high
      add(1, 1, 2,     0, 1, 0, 0, 0, 0);
      add(0, 1, 15,    0, 1, 0, 0, 0, 0);
      add(0, 1, 1,     1, 1, 0, 0, 0, 0);
      add(0, 1, 256,   1, 1, 0, 0, 0, 0);
      add(0, 1, 1,     1, 0, 1, 0, 0, 0);
      // lock loss in RUN and resequence
      add(0, 0, 2,     1, 0, 1, 0, 0, 0);
      add(0, 0, 1,     0, 1, 0, 0, 0, 1);
      add(0, 1, 272,   1, 1, 0, 0, 0, 1);
      add(0, 1, 1,     1, 0, 1, 0, 0, 1);
      // rst mid-STABLE
      add(0, 0, 3,     0, 1, 0, 0, 0, 2);
      add(0, 1, 67,    1, 1, 0, 0, 0, 2);
      add(1, 1, 1,     0, 1, 0, 0, 0, 0);
      // glitch at STABLE cnt=100
      add(0, 1, 117,   1, 1, 0, 0, 0, 0);
      add(0, 0, 3,     1, 1, 0, 0, 0, 0);
      add(0, 1, 258,   1, 1, 0, 0, 0, 0);
      add(0, 1, 1,     1, 0, 1, 0, 0, 0);
      // two timed-out attempts then lock
      add(1, 0, 1,     0, 1, 0, 0, 0, 0);
      add(0, 0, 4112,  0, 1, 0, 0, 1, 0);
      add(0, 0, 4112,  0, 1, 0, 0, 2, 0);
      add(0, 1, 15,    0, 1, 0, 0, 2, 0);
      add(0, 1, 1,     1, 1, 0, 0, 2, 0);
      add(0, 1, 256,   1, 1, 0, 0, 2, 0);
      add(0, 1, 1,     1, 0, 1, 0, 0, 0);
      // rst mid-PLL_RST clears cnt and loss_cnt
      add(0, 0, 3,     0, 1, 0, 0, 0, 1);
      add(0, 0, 5,     0, 1, 0, 0, 0, 1);
      add(1, 1, 1,     0, 1, 0, 0, 0, 0);
      add(0, 1, 15,    0, 1, 0, 0, 0, 0);
      add(0, 1, 1,     1, 1, 0, 0, 0, 0);
      // lock stuck low ends in FAIL
      add(1, 0, 1,     0, 1, 0, 0, 0, 0);
      add(0, 0, 16447, 1, 1, 0, 0, 3, 0);
      add(0, 0, 1,     0, 1, 0, 1, 3, 0);
      add(0, 1, 300,   0, 1, 0, 1, 3, 0);
      add(1, 1, 1,     0, 1, 0, 0, 0, 0);

      foreach (tv[i]) begin
         a_rst  = tv[i].rst;
         a_lock = tv[i].lock;
         repeat (tv[i].n) @(posedge clk);
         #1;
         got = {a_resetb, a_sysrst, a_ready, a_fail, a_retries, a_loss};
         checks++;
         if (got !== tv[i].exp) begin
            failures++;
            $display("FAIL vec%0d got=%h exp=%h", i, got, tv[i].exp);
         end
      end

      b_rst = 1'b1;
      b_edge();
      b_rst = 1'b0;
      for (int s = 0; s < 200; s++) begin
         lk = ($urandom_range(0, 99) < 60);
         if (lk) len = $urandom_range(1, 40);
         else if ($urandom_range(0, 9) == 0) len = $urandom_range(60, 120);
         else len = $urandom_range(1, 12);
         b_lock = lk;
         if ($urandom_range(0, 29) == 0) begin
            b_rst = 1'b1;
            b_edge();
            b_rst = 1'b0;
         end
         repeat (len) b_edge();
      end

      // loss counter saturation
      b_rst = 1'b1;
      b_edge();
      b_rst = 1'b0;
      for (int k = 0; k < 300; k++) begin
         b_lock = 1'b1;
         repeat (14) b_edge();
         b_lock = 1'b0;
         repeat (3) b_edge();
      end
      checks++;
      if (b_loss !== 8'd255) begin
         failures++;
         $display("FAIL loss_sat got=%0d exp=255", b_loss);
      end
      b_lock = 1'b1;
      repeat (20) b_edge();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
